baw_input_ctrl: RTL and testbench
=================================

Name: baw_input_ctrl

Overview:
- Front-end receiver for the black-and-white game board inputs: five push buttons and 16 switches.
- Synchronises, debounces and edge-detects the buttons, then emits a single-cycle command pulse with an encoded command code.
- Encodes the one-hot switch selection into a tile index, snapshotted with each command.
- Sits between the board pins and the baw_main game FSM, which consumes only clean one-cycle commands.

Parameters:
- DB_LIMIT, 1: consecutive synchronised samples a button must differ from its stable level before the stable level changes; legal range 1..255.
- SW_W, 16: switch bus width; index output is $clog2(SW_W) bits wide.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- btnCenter, btnTop, btnBottom, btnLeft, btnRight  in  1 each  raw asynchronous buttons, active-high.
- sw  in  SW_W  raw asynchronous switches.
- cmd_valid  out  1  one-cycle command strobe.
- cmd_code  out  3  command: 1=center, 2=top, 3=bottom, 4=left, 5=right; 0 when idle.
- cmd_sw_idx  out  $clog2(SW_W)  switch index captured with the command.
- cmd_sw_ok  out  1  exactly one switch bit was set at capture.
- sw_idx  out  $clog2(SW_W)  live index of the lowest set synchronised switch bit; 0 if none.
- sw_onehot  out  1  live: synchronised sw has exactly one bit set.
- sw_none  out  1  live: synchronised sw is all zero.

Behaviour:
- Reset: all sync flops, stable levels, debounce counters and pending bits are 0. Outputs reset to cmd_valid=0, cmd_code=0, cmd_sw_idx=0, cmd_sw_ok=0, sw_idx=0, sw_onehot=0, sw_none=1.
- Synchronisation: each button and each sw bit passes through 2 flops (s1, s2).
- Debounce, per button, counter cnt of width $clog2(DB_LIMIT+1):
  - If s2 == stable: cnt <= 0.
  - Else if cnt == DB_LIMIT-1: stable <= s2, cnt <= 0.
  - Else: cnt <= cnt+1.
  - Consequence: a level differing for fewer than DB_LIMIT consecutive s2 samples is ignored.
- Edge detect: rise = stable & ~stable_d.
  - Let N be the first edge sampling the raw button high. stable rises at edge N+DB_LIMIT+1; cmd_valid is registered high at edge N+DB_LIMIT+2 for exactly one cycle.
  - Holding a button yields one command. A new command requires release (stable low) and press again.
- Priority among rises in the same cycle: center > top > bottom > left > right.
  - The highest rise drives cmd_code. Lower rises are discarded, unless BAW_CMD_QUEUE_EN is defined.
- Command snapshot: on the cycle cmd_valid is registered, cmd_sw_idx <= sw_idx and cmd_sw_ok <= sw_onehot (values at that edge). Both hold until the next command.
- cmd_code returns to 0 when cmd_valid is 0.
- Switch encoder (sw_idx, sw_onehot, sw_none): registered from s2, so it lags raw sw by 3 edges.
  - Multiple bits set: sw_idx = lowest set bit, sw_onehot=0.
- Reset mid-operation: in-flight debounce and pending commands are dropped; no cmd_valid on the reset cycle. A button still held at reset release produces one command at normal latency, counting from the first post-reset sampling edge.
- Back-to-back presses of different buttons on consecutive cycles each produce their own command on consecutive cycles.

Optional Feature:
- Macro BAW_CMD_QUEUE_EN.
- Defined: a 5-bit pending register ORs in every rise not emitted that cycle. Each cycle emits the highest-priority bit of (rise | pending) and clears it. Simultaneous presses are therefore emitted on successive cycles in priority order, with no loss.
- Undefined: no pending register; lower-priority simultaneous rises are lost.
- rst clears pending in both builds.

Test Plan:
- DB_LIMIT=1: btnCenter high 1 cycle, sampled first at edge 10 -> cmd_valid=1, cmd_code=1 during the cycle after edge 13 only; no further strobe.
- DB_LIMIT=1: sw=16'h4000 settled, then btnTop pulse -> cmd_code=2, cmd_sw_idx=14, cmd_sw_ok=1. Repeat with sw=16'h0000 -> cmd_sw_ok=0, cmd_sw_idx=0, and sw_none=1.
- DB_LIMIT=3: btnLeft high 2 cycles -> no cmd_valid. btnLeft high 5 cycles -> exactly one cmd_code=4, first sampled at edge N, strobe after edge N+5.
- btnLeft and btnRight rise in the same cycle -> macro undefined: one strobe with cmd_code=4. Macro defined: cmd_code=4 then 5 on consecutive cycles.
- btnRight held through a 3-cycle rst assertion -> outputs at reset values during rst; one cmd_code=5 strobe DB_LIMIT+2 edges after the first post-reset sampling edge.
- sw=16'h0300 -> sw_idx=8, sw_onehot=0, sw_none=0, appearing 3 edges after the sw change.

Source files
------------

// File: rtl/baw_input_if.sv
// Board-side bundle for baw_input_ctrl: raw buttons and switches in,
// clean command strobe and live switch encoding out.
interface baw_input_if #(
  parameter int SW_W = 16
);
  localparam int IW = $clog2(SW_W);

  logic            btnCenter;
  logic            btnTop;
  logic            btnBottom;
  logic            btnLeft;
  logic            btnRight;
  logic [SW_W-1:0] sw;

  logic            cmd_valid;
  logic [2:0]      cmd_code;
  logic [IW-1:0]   cmd_sw_idx;
  logic            cmd_sw_ok;
  logic [IW-1:0]   sw_idx;
  logic            sw_onehot;
  logic            sw_none;

  modport master (
    output btnCenter, btnTop, btnBottom, btnLeft, btnRight, sw,
    input  cmd_valid, cmd_code, cmd_sw_idx, cmd_sw_ok,
    input  sw_idx, sw_onehot, sw_none
  );

  modport slave (
    input  btnCenter, btnTop, btnBottom, btnLeft, btnRight, sw,
    output cmd_valid, cmd_code, cmd_sw_idx, cmd_sw_ok,
    output sw_idx, sw_onehot, sw_none
  );
endinterface

// File: rtl/baw_input_ctrl.sv
// Button sync/debounce/edge-detect and switch encoder for the baw game.
// Optional BAW_CMD_QUEUE_EN keeps simultaneous presses as pending commands.
module baw_input_ctrl #(
  parameter int DB_LIMIT = 1,
  parameter int SW_W     = 16
) (
  input logic       clk,
  input logic       rst,
  baw_input_if.slave bus
);
  localparam int IW = $clog2(SW_W);
  localparam int CW = $clog2(DB_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(DB_LIMIT - 1);

  logic [4:0]      btn;
  logic [4:0]      b_s1, b_s2;
  logic [4:0]      stable, stable_d;
  logic [4:0]      rise, cand, pick;
  logic [CW-1:0]   cnt [5];
  logic [SW_W-1:0] sw_s1, sw_s2;
  logic [IW-1:0]   idx_c;
  logic            onehot_c, none_c;
  logic [2:0]      code_c;

  // bit 0 is the highest priority (center)
  assign btn = {bus.btnRight, bus.btnLeft, bus.btnBottom,
                bus.btnTop, bus.btnCenter};

  always_ff @(posedge clk) begin
    if (rst) begin
      b_s1     <= '0;
      b_s2     <= '0;
      stable   <= '0;
      stable_d <= '0;
      sw_s1    <= '0;
      sw_s2    <= '0;
      for (int b = 0; b < 5; b++) cnt[b] <= '0;
    end else begin
      b_s1     <= btn;
      b_s2     <= b_s1;
      stable_d <= stable;
      sw_s1    <= bus.sw;
      sw_s2    <= sw_s1;
      for (int b = 0; b < 5; b++) begin
        if (b_s2[b] == stable[b]) begin
          cnt[b] <= '0;
        end else if (cnt[b] == LIM) begin
          stable[b] <= b_s2[b];
          cnt[b]    <= '0;
        end else begin
          cnt[b] <= cnt[b] + CW'(1);
        end
      end
    end
  end

  assign rise = stable & ~stable_d;

`ifdef BAW_CMD_QUEUE_EN
  logic [4:0] pend;

  assign cand = rise | pend;

  always_ff @(posedge clk) begin
    if (rst) pend <= '0;
    else     pend <= cand & ~pick;
  end
`else
  assign cand = rise;
`endif

  assign pick = cand & (~cand + 5'd1);

  always_comb begin
    code_c = 3'd0;
    unique case (1'b1)
      pick[0]: code_c = 3'd1;
      pick[1]: code_c = 3'd2;
      pick[2]: code_c = 3'd3;
      pick[3]: code_c = 3'd4;
      pick[4]: code_c = 3'd5;
      default: code_c = 3'd0;
    endcase
  end

  always_comb begin
    idx_c = '0;
    for (int i = SW_W - 1; i >= 0; i--) begin
      if (sw_s2[i]) idx_c = IW'(i);
    end
    none_c   = (sw_s2 == '0);
    onehot_c = !none_c && ((sw_s2 & (sw_s2 - SW_W'(1))) == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.cmd_valid  <= 1'b0;
      bus.cmd_code   <= 3'd0;
      bus.cmd_sw_idx <= '0;
      bus.cmd_sw_ok  <= 1'b0;
      bus.sw_idx     <= '0;
      bus.sw_onehot  <= 1'b0;
      bus.sw_none    <= 1'b1;
    end else begin
      bus.cmd_valid <= |pick;
      bus.cmd_code  <= code_c;
      if (|pick) begin
        bus.cmd_sw_idx <= bus.sw_idx;
        bus.cmd_sw_ok  <= bus.sw_onehot;
      end
      bus.sw_idx    <= idx_c;
      bus.sw_onehot <= onehot_c;
      bus.sw_none   <= none_c;
    end
  end
endmodule

// File: tb/tb_baw_input_ctrl.sv
// Randomised bench for baw_input_ctrl at DB_LIMIT 1 and 3, checked every
// cycle against a sample-history model of sync, debounce and priority.
module tb_baw_input_ctrl;
  localparam int HN = 8192;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  btn = '0;
  logic [15:0] sw  = '0;

  always #5 clk = ~clk;

  baw_input_if #(.SW_W(16)) bus1 ();
  baw_input_if #(.SW_W(16)) bus3 ();

  assign bus1.btnCenter = btn[0];
  assign bus1.btnTop    = btn[1];
  assign bus1.btnBottom = btn[2];
  assign bus1.btnLeft   = btn[3];
  assign bus1.btnRight  = btn[4];
  assign bus1.sw        = sw;
  assign bus3.btnCenter = btn[0];
  assign bus3.btnTop    = btn[1];
  assign bus3.btnBottom = btn[2];
  assign bus3.btnLeft   = btn[3];
  assign bus3.btnRight  = btn[4];
  assign bus3.sw        = sw;

  baw_input_ctrl #(.DB_LIMIT(1), .SW_W(16)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );
  baw_input_ctrl #(.DB_LIMIT(3), .SW_W(16)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3)
  );

  // raw samples taken at each rising edge, 0 on reset edges
  logic [4:0]  bh [HN];
  logic [15:0] sh [HN];
  int k = 0;
  int last_rst = -1000;
  int dbl [2] = '{1, 3};

  logic [4:0] st [2];
  logic [4:0] std_ [2];
  logic [4:0] pend [2];
  int         lchg [2][5];
  logic       ev [2];
  logic [2:0] ec [2];
  logic [3:0] eci [2];
  logic       eok [2];
  logic [3:0] esi [2];
  logic       eoh [2];
  logic       enone [2];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [4:0] bsamp(int i);
    if (i < 0 || i <= last_rst) return 5'd0;
    return bh[i];
  endfunction

  function automatic logic [15:0] ssamp(int i);
    if (i < 0 || i <= last_rst) return 16'd0;
    return sh[i];
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, k, got, exp);
    end
  endtask

  task automatic model_step();
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        st[u] = '0; std_[u] = '0; pend[u] = '0;
        ev[u] = 1'b0; ec[u] = '0; eci[u] = '0; eok[u] = 1'b0;
        esi[u] = '0; eoh[u] = 1'b0; enone[u] = 1'b1;
        for (int b = 0; b < 5; b++) lchg[u][b] = k;
      end else begin
        logic [4:0] rise, cand, pk, smp;
        logic [15:0] v;
        logic flip;
        rise = st[u] & ~std_[u];
`ifdef BAW_CMD_QUEUE_EN
        cand = rise | pend[u];
`else
        cand = rise;
`endif
        pk = '0;
        ec[u] = '0;
        for (int b = 0; b < 5; b++) begin
          if (cand[b] && pk == '0) begin
            pk[b] = 1'b1;
            ec[u] = 3'(b + 1);
          end
        end
        ev[u] = (pk != '0);
        if (ev[u]) begin
          eci[u] = esi[u];
          eok[u] = eoh[u];
        end
        pend[u] = cand & ~pk;
        std_[u] = st[u];
        // level flips once the last DB samples since the last change all differ
        for (int b = 0; b < 5; b++) begin
          flip = 1'b1;
          for (int j = 0; j < dbl[u]; j++) begin
            smp = bsamp(k - 2 - j);
            if (k - j <= lchg[u][b] || smp[b] == st[u][b]) flip = 1'b0;
          end
          if (flip) begin
            st[u][b] = ~st[u][b];
            lchg[u][b] = k;
          end
        end
        v = ssamp(k - 2);
        esi[u] = '0;
        for (int i = 15; i >= 0; i--) if (v[i]) esi[u] = 4'(i);
        eoh[u] = ($countones(v) == 1);
        enone[u] = (v == '0);
      end
    end
    if (rst) begin
      bh[k] = '0;
      sh[k] = '0;
      last_rst = k;
    end else begin
      bh[k] = btn;
      sh[k] = sw;
    end
    k++;
  endtask

  task automatic check_outs();
    check("db1_valid", bus1.cmd_valid, ev[0]);
    check("db1_code", bus1.cmd_code, ec[0]);
    check("db1_cmd_idx", bus1.cmd_sw_idx, eci[0]);
    check("db1_cmd_ok", bus1.cmd_sw_ok, eok[0]);
    check("db1_sw_idx", bus1.sw_idx, esi[0]);
    check("db1_onehot", bus1.sw_onehot, eoh[0]);
    check("db1_none", bus1.sw_none, enone[0]);
    check("db3_valid", bus3.cmd_valid, ev[1]);
    check("db3_code", bus3.cmd_code, ec[1]);
    check("db3_cmd_idx", bus3.cmd_sw_idx, eci[1]);
    check("db3_cmd_ok", bus3.cmd_sw_ok, eok[1]);
    check("db3_sw_idx", bus3.sw_idx, esi[1]);
    check("db3_onehot", bus3.sw_onehot, eoh[1]);
    check("db3_none", bus3.sw_none, enone[1]);
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1;
      check_outs();
    end
  endtask

  task automatic press(input logic [4:0] m, input int len);
    btn = m;
    tick(len);
    btn = '0;
    tick(10);
  endtask

  initial begin
    tick(3);
    rst = 1'b0;
    tick(4);
    check("rst_none_live", bus1.sw_none, 1'b1);

    press(5'b00001, 1);
    sw = 16'h4000;
    tick(5);
    press(5'b00010, 1);
    check("top_idx14", bus1.cmd_sw_idx, 4'd14);
    sw = 16'h0000;
    tick(5);
    press(5'b00010, 1);
    check("top_ok0", bus1.cmd_sw_ok, 1'b0);

    press(5'b01000, 2);
    press(5'b01000, 5);
    press(5'b11000, 6);

    btn = 5'b10000;
    tick(4);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(10);
    btn = '0;
    tick(10);

    sw = 16'h0300;
    tick(4);
    check("sw0300_idx", bus1.sw_idx, 4'd8);

    btn = 5'b00001;
    tick(1);
    btn = 5'b00011;
    tick(6);
    btn = '0;
    tick(10);

    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 5; b++)
        if ($urandom_range(0, 5) == 0) btn[b] = ~btn[b];
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 3))
          0: sw = '0;
          1: sw = 16'd1 << $urandom_range(0, 15);
          2: sw = 16'($urandom);
          default: sw = (16'd1 << $urandom_range(0, 15))
                      | (16'd1 << $urandom_range(0, 15));
        endcase
      end
      rst = ($urandom_range(0, 399) == 0);
      tick(1);
    end
    rst = 1'b0;
    btn = '0;
    tick(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
